// File: rtl/in_intf_add_pkg.sv
// Shared types and helpers for the round-robin operand adder (in_intf_add_arb).
package in_intf_add_pkg;

  localparam int unsigned MAX_CH     = 32;
  localparam int unsigned MAX_CH_W   = 5;
  localparam int unsigned DATA_W_DEF = 4;
  localparam int unsigned NUM_CH_DEF = 2;

  // Channel-index width, never narrower than one bit.
  function automatic int unsigned ch_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [DATA_W_DEF-1:0]       sum;
    logic                        carry;
    logic [ch_w(NUM_CH_DEF)-1:0] ch;
  } res_t;

  // First set bit of valid at or after ptr, wrapping within num channels; ptr if none.
  function automatic int unsigned rr_pick(input logic [MAX_CH-1:0] valid,
                                          input int unsigned       ptr,
                                          input int unsigned       num);
    int unsigned idx;
    rr_pick = ptr;
    for (int k = MAX_CH - 1; k >= 0; k--) begin
      if (unsigned'(k) < num) begin
        idx = ptr + unsigned'(k);
        if (idx >= num) idx = idx - num;
        if (valid[idx[MAX_CH_W-1:0]]) rr_pick = idx;
      end
    end
  endfunction

endpackage

// File: rtl/in_intf_add_fifo.sv
// First-word-fall-through result FIFO with occupancy output.
module in_intf_add_fifo
  import in_intf_add_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = res_t,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  T            din,
  input  logic        pop,
  output T            dout,
  output logic        valid,
  output logic [AW:0] level
);

  T             mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push_c;
  logic          pop_c;

  always_comb begin
    push_c = push && (count < (AW+1)'(DEPTH));
    pop_c  = pop && (count != '0);
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (push_c) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_c) rd_ptr <= rd_ptr + 1'b1;
      case ({push_c, pop_c})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign valid = (count != '0);
  assign level = count;

endmodule

// File: rtl/in_intf_add_arb.sv
// Round-robin arbitration of NUM_CH operand channels into one registered adder and a result FIFO.
// Define IN_INTF_ADD_SAT_EN to clamp the sum to all-ones on carry-out.
module in_intf_add_arb
  import in_intf_add_pkg::*;
#(
  parameter int unsigned  DATA_W     = 4,
  parameter int unsigned  NUM_CH     = 2,
  parameter int unsigned  FIFO_DEPTH = 4,
  localparam int unsigned CH_W       = ch_w(NUM_CH),
  localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_a,
  input  logic [NUM_CH*DATA_W-1:0] in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_sum,
  output logic                     out_carry,
  output logic [CH_W-1:0]          out_ch,
  output logic [LVL_W-1:0]         fifo_level
);

  typedef struct packed {
    logic [DATA_W-1:0] sum;
    logic              carry;
    logic [CH_W-1:0]   ch;
  } res_w_t;

  logic [CH_W-1:0]   rr_ptr;
  logic              pipe_v;
  res_w_t            pipe_q;
  res_w_t            head_c;
  res_w_t            res_c;
  logic              space_c;
  logic              xfer_c;
  logic [CH_W-1:0]   grant_c;
  logic [DATA_W-1:0] op_a_c;
  logic [DATA_W-1:0] op_b_c;
  logic [DATA_W:0]   raw_c;

  // Credit counts the pipe entry as already occupying a FIFO slot; pops give no same-cycle credit.
  always_comb begin
    space_c  = (32'(fifo_level) + 32'(pipe_v)) < FIFO_DEPTH;
    grant_c  = CH_W'(rr_pick(MAX_CH'(in_valid), 32'(rr_ptr), NUM_CH));
    xfer_c   = reset && space_c && (|in_valid);
    in_ready = '0;
    op_a_c   = '0;
    op_b_c   = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      if (grant_c == CH_W'(c)) begin
        in_ready[c] = xfer_c;
        op_a_c      = in_a[c*DATA_W +: DATA_W];
        op_b_c      = in_b[c*DATA_W +: DATA_W];
      end
    end
    raw_c       = (DATA_W+1)'(op_a_c) + (DATA_W+1)'(op_b_c);
    res_c.ch    = grant_c;
    res_c.carry = raw_c[DATA_W];
`ifdef IN_INTF_ADD_SAT_EN
    res_c.sum   = raw_c[DATA_W] ? '1 : raw_c[DATA_W-1:0];
`else
    res_c.sum   = raw_c[DATA_W-1:0];
`endif
  end

  // Adder pipe stage and round-robin pointer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
      pipe_v <= 1'b0;
      pipe_q <= '0;
    end else begin
      pipe_v <= xfer_c;
      if (xfer_c) begin
        pipe_q <= res_c;
        rr_ptr <= (32'(grant_c) == NUM_CH - 1) ? '0 : grant_c + CH_W'(1);
      end
    end
  end

  in_intf_add_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (res_w_t)
  ) u_fifo (
    .clk   (clock),
    .rst_n (reset),
    .push  (pipe_v),
    .din   (pipe_q),
    .pop   (out_ready),
    .dout  (head_c),
    .valid (out_valid),
    .level (fifo_level)
  );

  assign out_sum   = head_c.sum;
  assign out_carry = head_c.carry;
  assign out_ch    = head_c.ch;

endmodule
